buttons_debounced: RTL

Parametrised multi-channel button front end that replaces raw-edge button handling. Each of N_BTN asynchronous button/keypad-column inputs is synchronised to hwclk, debounced with a per-channel stability counter, and turned into a clean level, one-cycle press/release pulses and a press-toggled register suitable for driving an LED directly. An optional long-press detector adds a one-shot pulse after a sustained hold. It sits between the keypad/button pins and user logic in every board top that reads buttons.

---
 rtl/buttons_pkg.sv | 15 +
 rtl/debounce_chan.sv | 129 ++++++++++++
 rtl/buttons_debounced.sv | 41 ++++
 3 files changed

// File: rtl/buttons_pkg.sv
// Shared constants for the button front end: system clock rate, default
// debounce / long-press durations and a millisecond-to-cycles helper.
package buttons_pkg;

    localparam int CLK_HZ = 12000000;

    // Number of hwclk cycles in the given number of milliseconds.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEFAULT_DB_CYCLES   = ms_to_cycles(10);    // 120000
    localparam int DEFAULT_HOLD_CYCLES = ms_to_cycles(1000);  // 12000000

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchroniser, polarity normalisation,
// stability-counter debounce, press/release pulses, press toggle and an
// optional long-press one-shot (compiled in with BUTTONS_LONGPRESS_EN).
//
// All outputs come straight from flops; there is no combinational path from
// the pin to any output.
module debounce_chan #(
    parameter int DB_CYCLES   = 120000,
    parameter int HOLD_CYCLES = 12000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic toggle_o,
    output logic long_o
);

    localparam int             CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DB_CYCLES - 1);
    // Pin value meaning "not pressed"; the synchroniser resets to it.
    localparam logic           IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          toggle_q, toggle_d;
    logic          pressed;
    logic          differs;

    // Synchroniser next state and polarity-normalised view (1 = pressed).
    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        pressed = sync2_q ^ IDLE_PIN;
        differs = (pressed != level_q);
    end

    // Debounce: count consecutive disagreeing cycles, accept on the last one;
    // any single agreeing cycle restarts the count.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        if (differs) begin
            if (cnt_q == CNT_MAX) begin
                level_d   = pressed;
                press_d   = pressed;
                release_d = ~pressed;
                toggle_d  = toggle_q ^ pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter and debounced outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= IDLE_PIN;
            sync2_q   <= IDLE_PIN;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign toggle_o  = toggle_q;

`ifdef BUTTONS_LONGPRESS_EN
    localparam int            HW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_q, long_d;

    // Hold counter: runs while pressed, saturates, so the pulse fires once.
    always_comb begin
        hold_cnt_d = '0;
        long_d     = 1'b0;
        if (level_q) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                long_d     = (hold_cnt_q == HOLD_MAX - 1'b1);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end

    assign long_o = long_q;
`else
    // Feature compiled out: constant 0 (HOLD_CYCLES has no effect here).
    assign long_o = 1'b0 & (HOLD_CYCLES > DB_CYCLES);
`endif

endmodule

// File: rtl/buttons_debounced.sv
// Multi-channel debounced button front end. Each pin gets its own
// debounce_chan; this level only passes parameters and builds the buses.
// Optional long-press detection is enabled by defining BUTTONS_LONGPRESS_EN;
// otherwise btn_long is constant 0.
module buttons_debounced
    import buttons_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int ACTIVE_LOW  = 1,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_toggle,
    output logic [N_BTN-1:0] btn_long
);

    // One independent channel per pin.
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk      (hwclk),
            .rst      (rst),
            .pin      (btn_in[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .toggle_o (btn_toggle[i]),
            .long_o   (btn_long[i])
        );
    end

endmodule
